jtframe_vubar: RTL and testbench

//  On-screen renderer for the volume-unit meter: consumes the vu[7:0] bar code and peak flag from the

---
 rtl/jtframe_vubar.sv | 211 +++++++++++++++++++++
 tb/tb_jtframe_vubar.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_vubar.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : jtframe_vubar                                                    |
// | Purpose : Video overlay for the VU meter. Draws an 8-segment bar and a     |
// |           clip box, with frame-based decay, a peak-hold marker and a clip  |
// |           latch.                                                           |
// | Ports   : clk, rst      clock, synchronous active-high reset               |
// |           pxl_cen       pixel clock enable                                 |
// |           lhbl, lvbl    active-low blanking (high = active video)          |
// |           en            overlay enable (meter state keeps running)         |
// |           vu[7:0]       bar code from the VU meter                         |
// |           peak          overflow flag, sampled on every clk                |
// |           ovl           pixel belongs to the overlay                       |
// |           rgb[8:0]      overlay colour {r,g,b}, valid while ovl=1          |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module jtframe_vubar #(
  parameter int X0     = 8,
  parameter int Y0     = 8,
  parameter int SEGW   = 6,
  parameter int SEGH   = 4,
  parameter int DECAY  = 4,
  parameter int HOLD   = 30,
  parameter int CLIPFR = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       lhbl,
  input  logic       lvbl,
  input  logic       en,
  input  logic [7:0] vu,
  input  logic       peak,
  output logic       ovl,
  output logic [8:0] rgb
);

  localparam int CW = $clog2(SEGW + 1);
  localparam int DW = (DECAY  > 1) ? $clog2(DECAY)  : 1;
  localparam int HW = (HOLD   > 1) ? $clog2(HOLD)   : 1;
  localparam int KW = (CLIPFR > 1) ? $clog2(CLIPFR) : 1;

  logic [8:0]    hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic          lhbl_q, lvbl_q;
  logic [CW-1:0] col_q, col_d;     // column inside the current slot (SEGW = gap)
  logic [3:0]    slot_q, slot_d;   // slot index, saturates at 15
  logic [3:0]    level_q, level_d, hold_q, hold_d;
  logic [DW-1:0] dec_cnt_q, dec_cnt_d, hdec_cnt_q, hdec_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          clip_q, clip_d;
  logic [KW-1:0] clip_cnt_q, clip_cnt_d;
  logic          ovl_q, ovl_d;
  logic [8:0]    rgb_q, rgb_d;

  logic          tick;
  logic [3:0]    new_lvl;
  logic          in_bar;
  logic [8:0]    seg_rgb;

  assign tick = pxl_cen & lvbl_q & ~lvbl;

  // Highest set bit wins, so broken thermometer codes still give a level.
  always_comb begin
    new_lvl = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (vu[i]) new_lvl = 4'(i + 1);
    end
  end

  // Raster counters plus a running slot/column tracker that follows hcnt,
  // so the slot of the current pixel never needs a divider.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    col_d  = col_q;
    slot_d = slot_q;
    if (pxl_cen) begin
      if (!lhbl) begin
        hcnt_d = 9'd0;
        col_d  = '0;
        slot_d = 4'd0;
      end else begin
        if (hcnt_q != 9'd511) hcnt_d = hcnt_q + 9'd1;
        if (hcnt_q >= 9'(X0)) begin
          if (col_q == CW'(SEGW)) begin
            col_d = '0;
            if (slot_q != 4'd15) slot_d = slot_q + 4'd1;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      if (!lvbl) vcnt_d = 9'd0;
      else if (lhbl_q && !lhbl && vcnt_q != 9'd511) vcnt_d = vcnt_q + 9'd1;
    end
  end

  // Meter state: level decay, peak hold and clip latch, all stepped by tick.
  always_comb begin
    level_d    = level_q;
    dec_cnt_d  = dec_cnt_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    hdec_cnt_d = hdec_cnt_q;
    clip_d     = clip_q;
    clip_cnt_d = clip_cnt_q;
    if (tick) begin
      if (new_lvl >= level_q) begin
        level_d   = new_lvl;
        dec_cnt_d = '0;
      end else if (dec_cnt_q == DW'(DECAY - 1)) begin
        level_d   = level_q - 4'd1;
        dec_cnt_d = '0;
      end else begin
        dec_cnt_d = dec_cnt_q + DW'(1);
      end

      if (new_lvl >= hold_q) begin
        hold_d     = new_lvl;
        hold_cnt_d = '0;
        hdec_cnt_d = '0;
      end else if (hold_cnt_q != HW'(HOLD - 1)) begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end else if (hdec_cnt_q == DW'(DECAY - 1)) begin
        hdec_cnt_d = '0;
        // The marker never drops below the freshly updated level.
        hold_d     = (hold_q - 4'd1 > level_d) ? hold_q - 4'd1 : level_d;
      end else begin
        hdec_cnt_d = hdec_cnt_q + DW'(1);
      end

      if (clip_q) begin
        if (clip_cnt_q == KW'(CLIPFR - 1)) clip_d = 1'b0;
        else clip_cnt_d = clip_cnt_q + KW'(1);
      end
    end
    // A new peak overrides the countdown, even on a tick cycle.
    if (peak) begin
      clip_d     = 1'b1;
      clip_cnt_d = '0;
    end
  end

  assign in_bar = (hcnt_q >= 9'(X0)) && (slot_q <= 4'd8) && (col_q != CW'(SEGW)) &&
                  (vcnt_q >= 9'(Y0)) && (vcnt_q <= 9'(Y0 + SEGH - 1));

  always_comb begin
    seg_rgb = 9'o111;
    if (slot_q == 4'd8) begin
      seg_rgb = clip_q ? 9'o700 : 9'o111;
    end else if (slot_q < level_q) begin
      if (slot_q <= 4'd5)      seg_rgb = 9'o070;
      else if (slot_q == 4'd6) seg_rgb = 9'o770;
      else                     seg_rgb = 9'o700;
    end else if (hold_q > level_q && slot_q == hold_q - 4'd1) begin
      seg_rgb = 9'o777;
    end
  end

  always_comb begin
    ovl_d = ovl_q;
    rgb_d = rgb_q;
    if (pxl_cen) begin
      ovl_d = en & lhbl & lvbl & in_bar;
      if (ovl_d) rgb_d = seg_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q     <= 9'd0;
      vcnt_q     <= 9'd0;
      lhbl_q     <= 1'b0;
      lvbl_q     <= 1'b0;
      col_q      <= '0;
      slot_q     <= 4'd0;
      level_q    <= 4'd0;
      dec_cnt_q  <= '0;
      hold_q     <= 4'd0;
      hold_cnt_q <= '0;
      hdec_cnt_q <= '0;
      clip_q     <= 1'b0;
      clip_cnt_q <= '0;
      ovl_q      <= 1'b0;
      rgb_q      <= 9'd0;
    end else begin
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      col_q      <= col_d;
      slot_q     <= slot_d;
      level_q    <= level_d;
      dec_cnt_q  <= dec_cnt_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      hdec_cnt_q <= hdec_cnt_d;
      clip_q     <= clip_d;
      clip_cnt_q <= clip_cnt_d;
      ovl_q      <= ovl_d;
      rgb_q      <= rgb_d;
      if (pxl_cen) begin
        lhbl_q <= lhbl;
        lvbl_q <= lvbl;
      end
    end
  end

  assign ovl = ovl_q;
  assign rgb = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_vubar.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_jtframe_vubar                                                 |
// | Purpose : Scoreboard bench for jtframe_vubar: directed and random frames,  |
// |           expected pixels come from a behavioural meter/geometry model.    |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_jtframe_vubar;

  localparam int X0 = 8, Y0 = 8, SEGW = 6, SEGH = 4, DECAY = 4, HOLD = 30, CLIPFR = 60;
  localparam int W = 74, HB = 2, H = 13;   // compact raster that still covers the bar

  logic       clk = 1'b0;
  logic       rst, pxl_cen, lhbl, lvbl, en, peak;
  logic [7:0] vu;
  logic       ovl;
  logic [8:0] rgb;

  always #5 clk = ~clk;

  jtframe_vubar #(.X0(X0), .Y0(Y0), .SEGW(SEGW), .SEGH(SEGH), .DECAY(DECAY),
                  .HOLD(HOLD), .CLIPFR(CLIPFR)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .lhbl(lhbl), .lvbl(lvbl), .en(en),
    .vu(vu), .peak(peak), .ovl(ovl), .rgb(rgb)
  );

  typedef struct { logic o; logic [8:0] c; int h; int v; } exp_t;
  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model state
  int m_h, m_v;
  bit m_lh, m_lv;
  int m_level, m_lage;      // displayed level and ticks since it was captured
  int m_hold,  m_hage;      // hold marker and ticks since it was captured
  bit m_clip_seen;
  int m_cage;               // non-peak ticks since last peak

  function automatic void model_reset();
    m_h = 0; m_v = 0; m_lh = 0; m_lv = 0;
    m_level = 0; m_lage = 0; m_hold = 0; m_hage = 0;
    m_clip_seen = 0; m_cage = 0;
  endfunction

  function automatic int top_level(input logic [7:0] v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i + 1;
    return r;
  endfunction

  function automatic void model_tick(input int nl);
    if (nl >= m_level) begin
      m_level = nl; m_lage = 0;
    end else begin
      m_lage++;
      if (m_lage % DECAY == 0) m_level--;
    end
    if (nl >= m_hold) begin
      m_hold = nl; m_hage = 0;
    end else begin
      m_hage++;
      if (m_hage >= HOLD && (m_hage - (HOLD - 1)) % DECAY == 0)
        m_hold = (m_hold - 1 > m_level) ? m_hold - 1 : m_level;
    end
  endfunction

  function automatic logic [8:0] colour(input int k);
    if (k == 8) return (m_clip_seen && m_cage < CLIPFR) ? 9'o700 : 9'o111;
    if (k < m_level) return (k <= 5) ? 9'o070 : (k == 6) ? 9'o770 : 9'o700;
    if (m_hold > m_level && k == m_hold - 1) return 9'o777;
    return 9'o111;
  endfunction

  // One clk: drive inputs, queue the expected output of the next edge, advance the model.
  task automatic cyc(input bit cen, input bit lh, input bit lv, input bit pk, input bit r);
    exp_t e;
    int   rel, k, c;
    @(posedge clk); #1;
    pxl_cen = cen; lhbl = lh; lvbl = lv; peak = pk; rst = r;
    if (r) begin
      e.o = 1'b0; e.c = 9'd0; e.h = -1; e.v = -1;
      q.push_back(e);
      model_reset();
    end else begin
      if (cen) begin
        rel = m_h - X0;
        k   = rel / (SEGW + 1);
        c   = rel % (SEGW + 1);
        e.h = m_h; e.v = m_v;
        e.o = en && lh && lv && m_h >= X0 && k <= 8 && c < SEGW &&
              m_v >= Y0 && m_v <= Y0 + SEGH - 1;
        e.c = e.o ? colour(k) : 9'd0;
        q.push_back(e);
        if (m_lv && !lv) begin
          model_tick(top_level(vu));
          if (!pk) m_cage++;
        end
        if (!lh) m_h = 0; else if (m_h < 511) m_h++;
        if (!lv) m_v = 0; else if (m_lh && !lh && m_v < 511) m_v++;
        m_lh = lh; m_lv = lv;
      end
      if (pk) begin m_clip_seen = 1; m_cage = 0; end
    end
  endtask

  task automatic pix(input bit lh, input bit lv, input bit pk, input bit r);
    if ($urandom_range(0, 3) == 0) cyc(1'b0, lh, lv, 1'b0, 1'b0);
    cyc(1'b1, lh, lv, pk, r);
  endtask

  // full=0 gives a degenerate frame: just enough raster for one tick.
  task automatic frame(input bit full, input int pk_at, input int rst_at, input bit pk_tick);
    int p = 0;
    int blen;
    if (full) begin
      for (int y = 0; y < H; y++) begin
        for (int x = 0; x < W + HB; x++) begin
          pix(x < W, 1'b1, p == pk_at, p == rst_at);
          p++;
        end
      end
    end else begin
      pix(1'b0, 1'b1, 1'b0, 1'b0);
    end
    blen = full ? W + HB : 2;
    for (int x = 0; x < blen; x++)
      pix(full && x < W, 1'b0, (x == 0) && pk_tick, 1'b0);
  endtask

  // Monitor: one queued expectation per edge that had pxl_cen or rst.
  initial begin
    bit   f;
    exp_t e;
    forever begin
      @(posedge clk);
      f = pxl_cen | rst;
      @(negedge clk);
      if (f) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_empty: DUT ovl=%0b rgb=%o, no expectation queued", ovl, rgb);
        end else begin
          e = q.pop_front();
          if (ovl !== e.o || (e.o && rgb !== e.c)) begin
            n_fail++;
            $display("FAIL pixel h=%0d v=%0d: got ovl=%0b rgb=%o, expected ovl=%0b rgb=%o",
                     e.h, e.v, ovl, rgb, e.o, e.c);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    rst = 0; pxl_cen = 0; lhbl = 0; lvbl = 0; en = 1; peak = 0; vu = 8'h00;
    model_reset();
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Idle meter
    vu = 8'h00;
    frame(1, -1, -1, 0);
    frame(1, -1, -1, 0);

    // Level decay and hold marker
    vu = 8'h3f;
    frame(1, -1, -1, 0);
    vu = 8'h00;
    for (int t = 1; t <= 45; t++)
      frame(t <= 6 || t == 25 || t == 30 || t == 31 || t == 34 || t == 38 || t == 42, -1, -1, 0);

    // Full scale
    vu = 8'hff;
    frame(1, -1, -1, 0);
    frame(1, -1, -1, 0);

    // Clip latch expiry
    vu = 8'h00;
    frame(1, 5 * (W + HB) + 20, -1, 0);
    for (int t = 1; t <= 61; t++) frame(t == 1 || t == 59 || t == 60, -1, -1, 0);

    // Clip restart by a peak coinciding with a tick
    frame(1, 3 * (W + HB) + 40, -1, 0);
    for (int t = 1; t <= 91; t++) frame(t == 61 || t == 89 || t == 90, -1, -1, t == 30);

    // Overlay disabled, meter keeps running
    vu = 8'h0f; en = 0;
    for (int t = 0; t < 10; t++) frame(t < 3, -1, -1, 0);
    en = 1;
    frame(1, -1, -1, 0);

    // Reset in the middle of a lit line
    vu = 8'hff;
    frame(1, -1, -1, 0);
    frame(1, -1, -1, 0);
    vu = 8'h00;
    frame(1, -1, 9 * (W + HB) + 30, 0);
    frame(1, -1, -1, 0);
    vu = 8'h0f;
    frame(1, -1, -1, 0);
    frame(1, -1, -1, 0);

    // Random traffic
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        nb = $urandom_range(0, 8);
        vu = 8'((9'd1 << nb) - 9'd1);
      end else begin
        vu = 8'($urandom);
      end
      en = ($urandom_range(0, 5) != 0);
      frame(t % 3 == 0,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, H * (W + HB) - 1)) : -1,
            -1, $urandom_range(0, 7) == 0);
    end

    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
